// File: rtl/float_mul_pipe.sv
// float_mul_pipe: pipelined multiplier for packed {sign, exponent, mantissa} floats under valid/ready flow control.
// Define FLOAT_MUL_ROUND_EN for round-half-up in normalisation; the default build truncates.
module float_mul_pipe #(
    parameter int N_mantisse = 23,
    parameter int N_exposant = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [N_exposant+N_mantisse:0]   op1,
    input  logic [N_exposant+N_mantisse:0]   op2,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [N_exposant+N_mantisse:0]   result
);
    localparam int NM = N_mantisse;
    localparam int NE = N_exposant;
    localparam int W  = 1 + NE + NM;

    localparam logic [NE+1:0] BIAS    = {3'b000, {(NE-1){1'b1}}};
    localparam logic [NE+1:0] EXP_MAX = {2'b00, {(NE-1){1'b1}}, 1'b0};
    localparam logic [NE+1:0] EXP_ONE = {{(NE+1){1'b0}}, 1'b1};

    logic           en;
    logic           c_valid;
    logic [W-1:0]   c_op1, c_op2;
    logic           s1_valid, s1_sign, s1_zero;
    logic [2*NM+1:0] s1_prod;
    logic [NE+1:0]  s1_exp;
    logic           s2_valid, s2_sign, s2_zero;
    logic [NM-1:0]  s2_mant;
    logic [NE+1:0]  s2_exp;

    logic [NE-1:0]  e1, e2;
    logic [NM-1:0]  m1, m2;
    logic [2*NM+1:0] prod_c;
    logic [NE+1:0]  exp_c;
    logic [NM-1:0]  norm_mant;
    logic [NE+1:0]  norm_exp;
    logic           unused_prod;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // Operand capture rank keeps the multiplier off the upstream register outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_valid <= 1'b0;
            c_op1   <= '0;
            c_op2   <= '0;
        end else if (en) begin
            c_valid <= in_valid;
            if (in_valid) begin
                c_op1 <= op1;
                c_op2 <= op2;
            end
        end
    end

    assign e1     = c_op1[W-2:NM];
    assign e2     = c_op2[W-2:NM];
    assign m1     = c_op1[NM-1:0];
    assign m2     = c_op2[NM-1:0];
    assign prod_c = {{(NM+1){1'b0}}, 1'b1, m1} * {{(NM+1){1'b0}}, 1'b1, m2};
    assign exp_c  = {2'b00, e1} + {2'b00, e2} - BIAS;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_prod  <= '0;
            s1_exp   <= '0;
        end else if (en) begin
            s1_valid <= c_valid;
            if (c_valid) begin
                s1_sign <= c_op1[W-1] ^ c_op2[W-1];
                s1_zero <= (e1 == '0) | (e2 == '0);
                s1_prod <= prod_c;
                s1_exp  <= exp_c;
            end
        end
    end

    assign unused_prod = ^s1_prod;

    // The product of two [1,2) significands lies in [1,4); a set top bit means shift right by one.
    always_comb begin
        norm_mant = s1_prod[2*NM-1:NM];
        norm_exp  = s1_exp;
`ifdef FLOAT_MUL_ROUND_EN
        begin : round_blk
            logic          round_bit;
            logic [NM:0]   round_sum;
            round_bit = s1_prod[NM-1];
            if (s1_prod[2*NM+1]) begin
                norm_mant = s1_prod[2*NM:NM+1];
                norm_exp  = s1_exp + EXP_ONE;
                round_bit = s1_prod[NM];
            end
            round_sum = {1'b0, norm_mant} + {{NM{1'b0}}, round_bit};
            norm_mant = round_sum[NM-1:0];
            if (round_sum[NM]) begin
                norm_exp = norm_exp + EXP_ONE;
            end
        end
`else
        if (s1_prod[2*NM+1]) begin
            norm_mant = s1_prod[2*NM:NM+1];
            norm_exp  = s1_exp + EXP_ONE;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b0;
            s2_mant  <= '0;
            s2_exp   <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign <= s1_sign;
                s2_zero <= s1_zero;
                s2_mant <= norm_mant;
                s2_exp  <= norm_exp;
            end
        end
    end

    // Exponent is signed here: a set MSB or zero means underflow, above EXP_MAX saturates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else if (en) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                if (s2_zero || s2_exp[NE+1] || (s2_exp == '0)) begin
                    result <= {s2_sign, {(W-1){1'b0}}};
                end else if (s2_exp > EXP_MAX) begin
                    result <= {s2_sign, EXP_MAX[NE-1:0], {NM{1'b1}}};
                end else begin
                    result <= {s2_sign, s2_exp[NE-1:0], s2_mant};
                end
            end
        end
    end
endmodule

// File: tb/tb_float_mul_pipe.sv
// tb_float_mul_pipe: vector table, backpressure, reset and random scoreboard checks for float_mul_pipe (Ne=8, Nm=23).
// Follows the FLOAT_MUL_ROUND_EN define for rounding expectations.
module tb_float_mul_pipe;
    localparam int NM = 23;
    localparam int NE = 8;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op1, op2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expect_res;
        string       name;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] exp_q[$];
    logic [31:0] stream_a[6];
    logic [31:0] stream_b[6];
    logic [31:0] stream_exp[6];

    float_mul_pipe #(.N_mantisse(NM), .N_exposant(NE)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference multiply on significand values: normalise into [2^23, 2^24), then saturate.
    function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     ea, eb, e;
        longint ma, mb, p, mant, rb;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0 || eb == 0) return {s, 31'd0};
        ma = 64'sd8388608 + longint'(a[22:0]);
        mb = 64'sd8388608 + longint'(b[22:0]);
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= 64'sd140737488355328) begin
            mant = p / 64'sd16777216;
            rb   = (p / 64'sd8388608) % 2;
            e    = e + 1;
        end else begin
            mant = p / 64'sd8388608;
            rb   = (p / 64'sd4194304) % 2;
        end
`ifdef FLOAT_MUL_ROUND_EN
        mant = mant + rb;
        if (mant == 64'sd16777216) begin
            mant = 64'sd8388608;
            e    = e + 1;
        end
`else
        rb = 0;
        mant = mant + rb;
`endif
        if (e < 1) return {s, 31'd0};
        if (e > 254) return {s, 8'hFE, 23'h7FFFFF};
        return {s, e[7:0], mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_float();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 1) == 0) v[30:23] = 8'($urandom_range(100, 154));
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Single pair through an empty pipe; entered and left just after a rising edge.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] req, input string name);
        in_valid  = 1'b1;
        op1       = a;
        op2       = b;
        out_ready = 1'b1;
        @(negedge clk);
        check_output({name, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_output({name, " early valid"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check_output({name, " out_valid"}, 32'(out_valid), 32'd1);
        check_output({name, " result"}, result, req);
        @(posedge clk);
        #1;
    endtask

    task automatic stream_source();
        int idx   = 0;
        int guard = 0;
        logic acc;
        while (idx < 6 && guard < 60) begin
            in_valid = 1'b1;
            op1      = stream_a[idx];
            op2      = stream_b[idx];
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            guard++;
        end
        in_valid = 1'b0;
        if (idx < 6) check_output("stream source timeout", 32'(idx), 32'd6);
    endtask

    task automatic stream_sink();
        int   waited = 0;
        logic [31:0] held;
        while (!out_valid && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!out_valid) begin
            check_output("stream first valid timeout", 32'(out_valid), 32'd1);
            return;
        end
        out_ready = 1'b0;
        @(negedge clk);
        check_output("stall in_ready drop", 32'(in_ready), 32'd0);
        held = result;
        for (int s = 0; s < 5; s++) begin
            if (s > 0) @(negedge clk);
            check_output($sformatf("stall%0d out_valid", s), 32'(out_valid), 32'd1);
            check_output($sformatf("stall%0d result stable", s), result, held);
            check_output($sformatf("stall%0d in_ready", s), 32'(in_ready), 32'd0);
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_output($sformatf("drain%0d out_valid", i), 32'(out_valid), 32'd1);
            check_output($sformatf("drain%0d result", i), result, stream_exp[i]);
            @(posedge clk);
        end
        #1;
    endtask

    // One scoreboard step per cycle: compare departures, record acceptances.
    task automatic monitor_step(input string tag);
        logic [31:0] front;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_output({tag, " spurious output"}, result, 32'hxxxxxxxx);
            end else begin
                front = exp_q.pop_front();
                check_output({tag, " result"}, result, front);
            end
        end
        if (in_valid && in_ready) exp_q.push_back(model_mul(op1, op2));
    endtask

    initial begin
        vecs[0] = '{32'h3FC00000, 32'h40000000, 32'h40400000, "nominal 1.5x2"};
        vecs[1] = '{32'hC0000000, 32'h40400000, 32'hC0C00000, "sign -2x3"};
        vecs[2] = '{32'h00000000, 32'h40A00000, 32'h00000000, "zero operand"};
        vecs[3] = '{32'h7F000000, 32'h7F000000, 32'h7F7FFFFF, "overflow"};
        vecs[4] = '{32'h00800000, 32'h80800000, 32'h80000000, "underflow"};
`ifdef FLOAT_MUL_ROUND_EN
        vecs[5] = '{32'h3FC00000, 32'h3F800001, 32'h3FC00002, "rounding"};
`else
        vecs[5] = '{32'h3FC00000, 32'h3F800001, 32'h3FC00001, "rounding"};
`endif
        vecs[6] = '{32'hBF800000, 32'hBF800000, 32'h3F800000, "-1x-1"};
        vecs[7] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, "1.5x1.5 shift"};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op1       = '0;
        op2       = '0;
        #3;
        check_output("reset out_valid", 32'(out_valid), 32'd0);
        check_output("reset result", result, 32'd0);
        check_output("reset in_ready", 32'(in_ready), 32'd1);
        #9 reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].expect_res, vecs[i].name);
        end

        $display("[TB] backpressure stream");
        for (int i = 0; i < 6; i++) begin
            stream_a[i]   = rand_float();
            stream_b[i]   = rand_float();
            stream_exp[i] = model_mul(stream_a[i], stream_b[i]);
        end
        out_ready = 1'b1;
        fork
            stream_source();
            stream_sink();
        join
        @(posedge clk);
        #1;

        $display("[TB] reset with items in flight");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            op1      = 32'h40000000;
            op2      = 32'h40400000;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_output("pre-reset out_valid", 32'(out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_output("mid reset out_valid", 32'(out_valid), 32'd0);
        check_output("mid reset result", result, 32'd0);
        check_output("mid reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_output($sformatf("post reset stale%0d", i), 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        apply_stimulus(32'h3FC00000, 32'h40000000, 32'h40400000, "post reset nominal");

        $display("[TB] random scoreboard");
        exp_q.delete();
        for (int c = 0; c < 300; c++) begin
            if (!(in_valid && !in_ready)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                op1      = rand_float();
                op2      = rand_float();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            monitor_step("random");
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            monitor_step("random drain");
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) check_output("random drain timeout", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
